// File: rtl/serial_subtractor8.sv
// Bit-serial 8-bit unsigned subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/busy/done handshake and held result registers.
module serial_subtractor8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] diff,
  output logic       bout,
  output logic       zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [7:0] res_q, res_d;
  logic [7:0] diff_q, diff_d;
  logic       br_q, br_d;
  logic       bout_q, bout_d;
  logic       zero_q, zero_d;
  logic [2:0] cnt_q, cnt_d;

  logic       dbit;
  logic       br_next;
  logic [7:0] res_shift;

  // Full-subtractor cell: returns {difference bit, borrow out}.
  function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bin);
    logic d;
    logic bo;
    d  = ai ^ bi ^ bin;
    bo = (~ai & bi) | (~(ai ^ bi) & bin);
    return {d, bo};
  endfunction

  assign {dbit, br_next} = full_sub(opa_q[0], opb_q[0], br_q);
  assign res_shift       = {dbit, res_q[7:1]};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          br_d    = 1'b0;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = res_shift;
        opa_d = {1'b0, opa_q[7:1]};
        opb_d = {1'b0, opb_q[7:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 3'd1;
        // Eighth bit: publish the full result in the same edge it completes.
        if (cnt_q == 3'd7) begin
          diff_d  = res_shift;
          bout_d  = br_next;
          zero_d  = (res_shift == 8'h00);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= 8'h00;
      opb_q   <= 8'h00;
      res_q   <= 8'h00;
      diff_q  <= 8'h00;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Bench for serial_subtractor8: directed scenarios plus randomized back-to-back
// operations checked against plain 9-bit arithmetic.
module tb_serial_subtractor8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       zero;

  int total = 0;
  int bad   = 0;

  serial_subtractor8 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero)
  );

  always #5 clk = ~clk;

  // Reference: unsigned subtraction with a 9th bit for the borrow.
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
    return {1'b0, x} - {1'b0, y};
  endfunction

  // Presents an operation for one accepting edge, then scrambles the operand inputs.
  task automatic launch(input logic [7:0] xa, input logic [7:0] xb);
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Observes cycles after the accepting edge until done (bounded).
  task automatic wait_done(output int nbusy, output bit got, output bit both);
    nbusy = 0;
    got   = 1'b0;
    both  = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (busy && done) both = 1'b1;
      if (busy) nbusy++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (diff !== 8'h00) begin bad++; $display("FAIL reset_diff got=%h want=00", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b want=0", bout); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nb; bit got; bit both;
    launch(8'h5A, 8'h3C);
    wait_done(nb, got, both);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", got); end
    total++; if (nb != 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", nb); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL basic_busy_done_overlap got=%b want=0", both); end
    total++; if (diff !== 8'h1E) begin bad++; $display("FAIL basic_diff got=%h want=1e", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL basic_bout got=%b want=0", bout); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL basic_zero got=%b want=0", zero); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    total++; if (diff !== 8'h1E) begin bad++; $display("FAIL basic_diff_hold got=%h want=1e", diff); end
  endtask

  task automatic test_borrow();
    int nb; bit got; bit both;
    launch(8'h10, 8'h20);
    wait_done(nb, got, both);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL borrow1_done got=%b want=1", got); end
    total++; if ({bout, diff} !== 9'h1F0) begin bad++; $display("FAIL borrow1_result got=%b_%h want=1_f0", bout, diff); end
    launch(8'h00, 8'hFF);
    wait_done(nb, got, both);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL borrow2_done got=%b want=1", got); end
    total++; if ({bout, diff} !== 9'h101) begin bad++; $display("FAIL borrow2_result got=%b_%h want=1_01", bout, diff); end
  endtask

  task automatic test_zero();
    int nb; bit got; bit both;
    launch(8'h77, 8'h77);
    wait_done(nb, got, both);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", got); end
    total++; if (diff !== 8'h00) begin bad++; $display("FAIL zero_diff got=%h want=00", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL zero_bout got=%b want=0", bout); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL zero_flag got=%b want=1", zero); end
  endtask

  task automatic test_mid_change();
    int ndone = 0;
    int nbusy_after = 0;
    bit seen = 1'b0;
    bit timeout;
    launch(8'hC8, 8'h01);
    start = 1'b1;
    timeout = 1'b1;
    // Hold start high with changing operands through SHIFT and DONE.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      if (seen) begin
        timeout = 1'b0;
        break;
      end
      if (done) begin
        ndone++;
        seen = 1'b1;
      end
    end
    start = 1'b0;
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL mid_done_timeout got=%b want=0", timeout); end
    total++; if (diff !== 8'hC7) begin bad++; $display("FAIL mid_diff got=%h want=c7", diff); end
    total++; if (bout !== 1'b0) begin bad++; $display("FAIL mid_bout got=%b want=0", bout); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) nbusy_after++;
      if (done) ndone++;
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL mid_done_count got=%0d want=1", ndone); end
    total++; if (nbusy_after != 0) begin bad++; $display("FAIL mid_extra_op got=%0d busy cycles want=0", nbusy_after); end
  endtask

  task automatic test_reset_mid();
    int nb; bit got; bit both;
    launch(8'h33, 8'h11);
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({busy, done, bout, zero} !== 4'b0000) begin bad++; $display("FAIL rmid_flags got=%b want=0000", {busy, done, bout, zero}); end
    total++; if (diff !== 8'h00) begin bad++; $display("FAIL rmid_diff_clear got=%h want=00", diff); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_no_done got=%b want=0", done); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    wait_done(nb, got, both);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rmid_done got=%b want=1", got); end
    total++; if (nb != 8) begin bad++; $display("FAIL rmid_busy_cycles got=%0d want=8", nb); end
    total++; if ({bout, diff} !== 9'h0FF) begin bad++; $display("FAIL rmid_result got=%b_%h want=0_ff", bout, diff); end
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL rmid_zero got=%b want=0", zero); end
  endtask

  task automatic test_back_to_back();
    int nb; bit got; bit both;
    logic [7:0] xa, xb;
    logic [8:0] exp;
    for (int k = 0; k < 30; k++) begin
      xa = 8'($urandom);
      xb = (k % 5 == 0) ? xa : 8'($urandom);
      exp = ref_sub(xa, xb);
      launch(xa, xb);
      wait_done(nb, got, both);
      total++;
      if (got !== 1'b1 || nb != 8 || both !== 1'b0) begin
        bad++;
        $display("FAIL b2b_handshake[%0d] got done=%b busy=%0d overlap=%b want 1/8/0", k, got, nb, both);
      end
      total++;
      if ({bout, diff, zero} !== {exp, (exp[7:0] == 8'h00)}) begin
        bad++;
        $display("FAIL b2b_result[%0d] a=%h b=%h got=%b_%h_%b want=%b_%h_%b", k, xa, xb,
                 bout, diff, zero, exp[8], exp[7:0], (exp[7:0] == 8'h00));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_mid_change();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor8.md
# serial_subtractor8

Bit-serial 8-bit subtractor that computes `a - b` using one full-subtractor cell and a borrow flip-flop, one bit per clock, LSB first. It is the inverse-direction companion to the team's 8-bit ripple adder. It trades area for latency in datapaths where one result per ~10 cycles is enough. A start/busy/done handshake launches each operation, and results are held in output registers until the next operation completes.

## Interface
Parameters: none. Width is fixed at 8.

- `clk`  input  1  single clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request; sampled only in IDLE
- `a`  input  8  minuend; captured on the accepted start edge
- `b`  input  8  subtrahend; captured on the accepted start edge
- `busy`  output  1  high while in SHIFT
- `done`  output  1  one-cycle pulse; new result valid
- `diff`  output  8  `(a - b) mod 256` of the last completed operation
- `bout`  output  1  borrow out; 1 iff a < b (unsigned)
- `zero`  output  1  1 iff `diff == 0`

## Operation
- State machine: IDLE, SHIFT, DONE.
- Reset (`rst` high at a rising edge):
  - state goes to IDLE.
  - `busy`, `done`, `diff`, `bout`, `zero` all go to 0.
  - internal shift registers, borrow flop and counter clear.
  - `rst` has priority over every other input.
- IDLE, `start` = 1:
  - load `a` and `b` into internal operand shift registers.
  - borrow flop = 0, bit counter = 0.
  - go to SHIFT.
- IDLE, `start` = 0: hold.
- SHIFT, every cycle, with `ai` = operand A bit 0, `bi` = operand B bit 0, `br` = borrow flop:
  - `d = ai ^ bi ^ br`
  - `br_next = (~ai & bi) | (~(ai ^ bi) & br)`
  - shift `d` into the MSB of the internal result shift register.
  - shift both operand registers right by one bit.
  - increment the counter.
- SHIFT exit: when counter == 7, which is the 8th SHIFT cycle:
  - copy the completed result register to `diff`.
  - set `bout` = `br_next`.
  - set `zero` = (final result == 0).
  - go to DONE.
- DONE:
  - `done` = 1 for exactly this cycle.
  - next state is IDLE unconditionally.
  - `start` asserted in DONE is ignored.
- `start` is ignored in SHIFT. An in-flight operation is never restarted or corrupted.
- `a` and `b` may change freely after the accepted start edge without affecting the result.
- `diff`, `bout` and `zero` change only on the edge entering DONE or on reset. They never show partial values while busy.
- Arithmetic:
  - unsigned, modulo 256.
  - for 8-bit unsigned inputs, `{bout, diff}` = `{1'b0, a} - {1'b0, b}`.

## Timing
- Edge T0 samples `start` = 1 in IDLE.
- `busy` = 1 during the 8 cycles following T0, i.e. the cycles after edges T0 through T0+7.
- The edge at T0+8 updates `diff`, `bout` and `zero`.
- `done` = 1 in the cycle after T0+8.
- Latency from the accepting edge to `done` high: 8 edges. Results are valid in the same cycle `done` is high and are held afterwards.
- Next `start` is accepted earliest at edge T0+10, the first IDLE edge. Throughput is 1 operation per 10 cycles with back-to-back starts.
- `busy` and `done` are never high simultaneously.
- Reset mid-operation:
  - the operation is abandoned and no `done` is produced.
  - outputs clear on that edge.
  - `start` held high through reset release is accepted at the first edge with `rst` = 0.

## Test plan
- Reset: hold `rst` for 2 cycles. Expect `busy` = 0, `done` = 0, `diff` = 0x00, `bout` = 0, `zero` = 0.
- a = 0x5A, b = 0x3C, start pulse. Expect `done` 8 edges later with `diff` = 0x1E, `bout` = 0, `zero` = 0, and `busy` high for exactly 8 cycles.
- a = 0x10, b = 0x20, then a = 0x00, b = 0xFF. Expect `diff` = 0xF0 with `bout` = 1, then `diff` = 0x01 with `bout` = 1.
- a = 0x77, b = 0x77. Expect `diff` = 0x00, `bout` = 0, `zero` = 1.
- Mid-operation input changes: start with a = 0xC8, b = 0x01. Change a/b and pulse `start` during busy and during DONE. Expect a single `done` with `diff` = 0xC7, and no extra operation.
- Reset after the 4th SHIFT cycle. Expect no `done`, outputs cleared, then a new a = 0xFF, b = 0x00 operation giving `diff` = 0xFF, `bout` = 0.
